mul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one multi-cycle fixed-point multiplier (trigger/ready/done handshake) between NUM_REQ requesters, e.g. synthesizer voice channels.
- Latches the granted requester's operands, triggers the multiplier, waits for done, then returns the result tagged to the originating requester.
- Includes a watchdog that recovers from a multiplier that never signals done.

---
 rtl/mul_arbiter_pkg.sv | 20 ++
 rtl/mul_arbiter_rr_priority_picker.sv | 29 ++
 rtl/mul_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mul_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arbiter_pkg.sv
// Shared types and helpers for the multiplier arbiter: FSM state encoding and a
// constant-context clog2 used to size grant indices and the watchdog.
package mul_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
// No state; any_req is low when nothing is pending.
module mul_arbiter_rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest so the requester closest after last_grant wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant   = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle multiplier among NUM_REQ requesters: grant->ack 1 cycle, ack->trigger
// 1 cycle, done->response 1 cycle; grants only when the multiplier reports ready, watchdog aborts.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int C_WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       ctl_clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*C_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*C_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]         req_signed,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [C_WIDTH-1:0]         resp_y,
  output logic                       resp_err,
  output logic                       busy,
  output logic [C_WIDTH-1:0]         mul_a,
  output logic [C_WIDTH-1:0]         mul_b,
  output logic                       mul_signed,
  output logic                       mul_trigger,
  input  logic                       mul_ready,
  input  logic                       mul_done,
  input  logic [C_WIDTH-1:0]         mul_y
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int WD_W  = clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [C_WIDTH-1:0] resp_y_q, resp_y_d;
  logic               resp_err_q, resp_err_d;
  logic               busy_q, busy_d;
  logic [C_WIDTH-1:0] mul_a_q, mul_a_d;
  logic [C_WIDTH-1:0] mul_b_q, mul_b_d;
  logic               mul_signed_q, mul_signed_d;
  logic               mul_trigger_q, mul_trigger_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               any_req;
  logic [C_WIDTH-1:0] sel_a, sel_b;
  logic               sel_s;

  mul_arbiter_rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (pick_idx),
    .any_req    (any_req)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_a = req_a[i*C_WIDTH +: C_WIDTH];
        sel_b = req_b[i*C_WIDTH +: C_WIDTH];
        sel_s = req_signed[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    wd_d          = wd_q;
    req_ack_d     = '0;
    resp_valid_d  = '0;
    resp_y_d      = resp_y_q;
    resp_err_d    = resp_err_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    mul_signed_d  = mul_signed_q;
    mul_trigger_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req && mul_ready) begin
          grant_d             = pick_idx;
          last_grant_d        = pick_idx;
          mul_a_d             = sel_a;
          mul_b_d             = sel_b;
          mul_signed_d        = sel_s;
          req_ack_d[pick_idx] = 1'b1;
          state_d             = ISSUE;
        end
      end
      ISSUE: begin
        mul_trigger_d = 1'b1;
        wd_d          = '0;
        state_d       = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        // A done arriving on the timeout cycle still delivers the real result.
        if (mul_done) begin
          resp_y_d              = mul_y;
          resp_err_d            = 1'b0;
          resp_valid_d[grant_q] = 1'b1;
          state_d               = IDLE;
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          resp_y_d              = '0;
          resp_err_d            = 1'b1;
          resp_valid_d[grant_q] = 1'b1;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ctl_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      grant_q       <= '0;
      wd_q          <= '0;
      req_ack_q     <= '0;
      resp_valid_q  <= '0;
      resp_y_q      <= '0;
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_signed_q  <= 1'b0;
      mul_trigger_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      wd_q          <= wd_d;
      req_ack_q     <= req_ack_d;
      resp_valid_q  <= resp_valid_d;
      resp_y_q      <= resp_y_d;
      resp_err_q    <= resp_err_d;
      busy_q        <= busy_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_signed_q  <= mul_signed_d;
      mul_trigger_q <= mul_trigger_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign resp_valid  = resp_valid_q;
  assign resp_y      = resp_y_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_signed  = mul_signed_q;
  assign mul_trigger = mul_trigger_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: fixed-point multiplier model (5-cycle latency, 8 fraction bits),
// transaction-level reference for grant order, timing and responses.
module tb_mul_arbiter;

  localparam int CW  = 32;
  localparam int N   = 4;
  localparam int TO  = 8;
  localparam int LAT = 5;
  localparam int FP  = 8;

  logic          ctl_clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*CW-1:0] req_a = '0;
  logic [N*CW-1:0] req_b = '0;
  logic [N-1:0]  req_signed = '0;
  logic [N-1:0]  req_ack, resp_valid;
  logic [CW-1:0] resp_y, mul_a, mul_b;
  logic          resp_err, busy, mul_signed, mul_trigger;
  logic          mul_ready = 1'b0;
  logic          mul_done = 1'b0;
  logic [CW-1:0] mul_y = '0;

  always #5 ctl_clk = ~ctl_clk;

  mul_arbiter #(.C_WIDTH(CW), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .ctl_clk(ctl_clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_signed(req_signed), .req_ack(req_ack), .resp_valid(resp_valid), .resp_y(resp_y),
    .resp_err(resp_err), .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed),
    .mul_trigger(mul_trigger), .mul_ready(mul_ready), .mul_done(mul_done), .mul_y(mul_y)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // reference state
  int phase = 0;
  int t = 0;
  int last = N - 1;
  int cur = 0;
  logic [CW-1:0] cur_a, cur_b;
  logic cur_s;
  logic [N-1:0] req_prev;
  logic [N*CW-1:0] a_prev, b_prev;
  logic [N-1:0] s_prev;
  logic rdy_prev, done_prev, rst_prev;
  logic [CW-1:0] y_prev;

  // multiplier and requester models
  int rem [N];
  logic rdy_force = 1'b1;
  logic mul_busy = 1'b0;
  logic hang_cur = 1'b0;
  logic hang_next = 1'b0;
  int mul_cnt = 0;
  logic [CW-1:0] mul_res = '0;

  // observed history
  int trig_cyc = 0, resp_cyc = 0, ack_cyc = 0, load_cyc = 0, resp_count = 0;
  logic trig_signed = 1'b0;
  logic [CW-1:0] last_y = '0;
  logic last_err = 1'b0;
  logic [N-1:0] last_resp_vec = '0;
  int ack_log [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] fx_mul(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic s);
    logic [63:0] p;
    if (s) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else   p = 64'(a) * 64'(b);
    return p[CW+FP-1:FP];
  endfunction

  function automatic int rr_pick(input logic [N-1:0] req, input int last_g);
    logic [N-1:0] sh;
    for (int k = 1; k <= N; k++) begin
      sh = req >> ((last_g + k) % N);
      if (sh[0]) return (last_g + k) % N;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic all_idle();
    for (int i = 0; i < N; i++) if (rem[i] != 0) return 1'b0;
    return (phase == 0);
  endfunction

  task automatic step();
    logic [N-1:0] exp_ack, exp_resp;
    logic exp_trig, exp_err;
    logic [CW-1:0] exp_y;
    int g;
    req_prev = req_valid; a_prev = req_a; b_prev = req_b; s_prev = req_signed;
    rdy_prev = mul_ready; done_prev = mul_done; y_prev = mul_y; rst_prev = reset;
    @(negedge ctl_clk);
    cyc++;
    exp_ack = '0; exp_resp = '0; exp_trig = 1'b0; exp_err = 1'b0; exp_y = '0;
    if (rst_prev) begin
      phase = 0;
      last = N - 1;
    end else if (phase == 0) begin
      g = rr_pick(req_prev, last);
      if (rdy_prev && g >= 0) begin
        exp_ack = N'(1) << g;
        last = g; cur = g;
        cur_a = a_prev[g*CW +: CW]; cur_b = b_prev[g*CW +: CW];
        cur_s = s_prev[g];
        phase = 1;
      end
    end else if (phase == 1) begin
      exp_trig = 1'b1;
      phase = 2;
      t = 0;
    end else begin
      t++;
      if (done_prev) begin
        exp_resp = N'(1) << cur; exp_y = y_prev; phase = 0;
      end else if (t == TO + 1) begin
        exp_resp = N'(1) << cur; exp_err = 1'b1; phase = 0;
      end
    end

    if (rst_prev) begin
      check("rst_flags", {req_ack, resp_valid, resp_err, busy, mul_trigger, mul_signed}, 64'd0);
      check("rst_resp_y", resp_y, 64'd0);
      check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
    end else begin
      check("ack", req_ack, exp_ack);
      check("resp_valid", resp_valid, exp_resp);
      check("trigger", mul_trigger, exp_trig);
      check("busy", busy, phase != 0);
      if (exp_trig) begin
        check("mul_a", mul_a, cur_a);
        check("mul_b", mul_b, cur_b);
        check("mul_signed", mul_signed, cur_s);
      end
      if (exp_resp != 0) begin
        check("resp_y", resp_y, exp_y);
        check("resp_err", resp_err, exp_err);
      end
    end
    if (mul_trigger) begin trig_cyc = cyc; trig_signed = mul_signed; end
    if (req_ack != 0) begin ack_cyc = cyc; ack_log.push_back(idx_of(req_ack)); end
    if (resp_valid != 0) begin
      resp_cyc = cyc; last_y = resp_y; last_err = resp_err;
      last_resp_vec = resp_valid; resp_count++;
    end

    // multiplier peer
    if (rst_prev) begin
      mul_busy = 1'b0; mul_done = 1'b0;
    end else begin
      if (mul_done) begin mul_done = 1'b0; mul_busy = 1'b0; end
      if (mul_trigger) begin
        mul_busy = 1'b1; mul_cnt = LAT; hang_cur = hang_next;
        mul_res = fx_mul(mul_a, mul_b, mul_signed);
      end else if (mul_busy && !hang_cur) begin
        mul_cnt--;
        if (mul_cnt == 0) mul_done = 1'b1;
      end
      if (resp_err && resp_valid != 0) mul_busy = 1'b0;
    end
    mul_y = mul_done ? mul_res : CW'($urandom);
    mul_ready = !mul_busy && rdy_force;

    // requesters: hold until acked, then reload or drop
    for (int i = 0; i < N; i++) begin
      if (!rst_prev && req_ack[i]) begin
        rem[i]--;
        req_a[i*CW +: CW] = CW'($urandom);
        req_b[i*CW +: CW] = CW'($urandom);
        req_signed[i] = 1'($urandom_range(0, 1));
      end
      req_valid[i] = (rem[i] > 0);
    end
  endtask

  task automatic load(input int i, input int n, input logic [CW-1:0] a, input logic [CW-1:0] b,
                      input logic s);
    rem[i] = n;
    req_a[i*CW +: CW] = a;
    req_b[i*CW +: CW] = b;
    req_signed[i] = s;
    req_valid[i] = 1'b1;
    load_cyc = cyc;
  endtask

  task automatic set_rdy(input logic v);
    rdy_force = v;
    mul_ready = !mul_busy && v;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    set_rdy(1'b1);
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    check("drain", all_idle(), 1'b1);
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) rem[i] = 0;
    req_valid = '0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int rc, rdy_cyc, n_acks;
    for (int i = 0; i < N; i++) rem[i] = 0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // single unsigned request
    load(0, 1, 32'h0000_0300, 32'h0000_0200, 1'b0);
    drain(60);
    check("t1_trig_lat", trig_cyc - load_cyc, 2);
    check("t1_resp_vec", last_resp_vec, 4'b0001);
    check("t1_y", last_y, 32'h0000_0600);
    check("t1_err", last_err, 1'b0);

    // signed request
    load(2, 1, 32'hFFFF_FE00, 32'h0000_0180, 1'b1);
    drain(60);
    check("t2_mul_signed", trig_signed, 1'b1);
    check("t2_resp_vec", last_resp_vec, 4'b0100);
    check("t2_y", last_y, 32'hFFFF_FD00);

    // round robin, all held high
    do_reset();
    ack_log.delete();
    for (int i = 0; i < N; i++) load(i, 2, CW'($urandom), CW'($urandom), 1'($urandom_range(0, 1)));
    drain(400);
    check("t3_count", ack_log.size(), 8);
    for (int k = 0; k < 8; k++) check("t3_order", (k < ack_log.size()) ? ack_log[k] : -1, k % 4);

    // multiplier not ready
    set_rdy(1'b0);
    n_acks = ack_log.size();
    load(1, 1, CW'($urandom), CW'($urandom), 1'b0);
    repeat (4) step();
    check("t4_no_ack", ack_log.size(), n_acks);
    check("t4_busy", busy, 1'b0);
    set_rdy(1'b1);
    rdy_cyc = cyc;
    step();
    check("t4_ack_lat", ack_cyc - rdy_cyc, 1);
    drain(60);

    // watchdog on a multiplier that never finishes
    hang_next = 1'b1;
    load(2, 1, CW'($urandom), CW'($urandom), 1'b0);
    drain(100);
    hang_next = 1'b0;
    check("t5_err", last_err, 1'b1);
    check("t5_y", last_y, 32'd0);
    check("t5_lat", resp_cyc - trig_cyc, 9);
    check("t5_vec", last_resp_vec, 4'b0100);
    step();
    check("t5_idle", busy, 1'b0);

    // reset while waiting on the multiplier
    load(0, 1, CW'($urandom), CW'($urandom), 1'b0);
    repeat (4) step();
    check("t6_busy_before", busy, 1'b1);
    rc = resp_count;
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (10) step();
    check("t6_no_resp", resp_count, rc);
    load(3, 1, CW'($urandom), CW'($urandom), 1'b1);
    drain(60);
    check("t6_ack3", ack_log[ack_log.size()-1], 3);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < N; i++)
        if (rem[i] == 0 && $urandom_range(0, 3) == 0)
          load(i, int'($urandom_range(1, 3)), CW'($urandom), CW'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) set_rdy(!rdy_force);
      hang_next = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 6)) step();
    end
    hang_next = 1'b0;
    drain(3000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
